// File: rtl/dsp_chan_mux_pkg.sv
// Shared types and helpers for the dsp_chan_mux stream concentrator.
// Holds the arbiter state encoding, the round-robin pick function and the stats counter width.
package dsp_pkg;

    localparam int STATS_W  = 32;
    localparam int MAX_CH   = 16;
    localparam int CH_IDX_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // First set bit of req at or above ptr, wrapping modulo MAX_CH; unused upper req bits must be zero.
    function automatic logic [CH_IDX_W-1:0] rr_pick(input logic [MAX_CH-1:0]   req,
                                                   input logic [CH_IDX_W-1:0] ptr);
        logic [CH_IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            idx = ptr + CH_IDX_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/dsp_chan_mux_fifo.sv
// dsp_sync_fifo: per-channel synchronous FIFO with flush, power-of-two depth.
// head always presents the oldest entry; a push is ignored while full.
module dsp_sync_fifo
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DATA_WIDTH-1:0]       head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries only data, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/dsp_chan_mux.sv
// dsp_chan_mux: NUM_CH valid/ready streams, per-channel FIFOs, burst-limited round-robin egress.
// Define DSP_CHAN_MUX_STATS_EN to add stats_clr and per-channel beat_count counters.
module dsp_chan_mux
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_LEN  = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic [NUM_CH-1:0]                 ch_enable,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] src_data_in,
    input  logic [NUM_CH-1:0]                 src_valid_in,
    output logic [NUM_CH-1:0]                 src_ready_out,
`ifdef DSP_CHAN_MUX_STATS_EN
    input  logic                              stats_clr,
    output logic [NUM_CH-1:0][STATS_W-1:0]    beat_count,
`endif
    output logic [DATA_WIDTH-1:0]             dst_data_out,
    output logic [CH_W-1:0]                   dst_chan_out,
    output logic                              dst_valid_out,
    input  logic                              dst_ready_in
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BC_W  = $clog2(BURST_LEN + 1);

    logic [NUM_CH-1:0]                 push;
    logic [NUM_CH-1:0]                 pop;
    logic [NUM_CH-1:0]                 flush;
    logic [NUM_CH-1:0]                 full;
    logic [NUM_CH-1:0]                 empty;
    logic [NUM_CH-1:0][CNT_W-1:0]      count;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] head;
    logic [NUM_CH-1:0]                 req;
    logic [NUM_CH-1:0]                 last_beat;
    logic [MAX_CH-1:0]                 req_ext;

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BC_W-1:0]   beat_inc;
    logic [CH_W-1:0]   pick_ch;
    logic [CH_W-1:0]   pop_ch;
    logic              pop_en;
    logic              load_opp;

    logic                  dst_valid_q;
    logic [DATA_WIDTH-1:0] dst_data_q;
    logic [CH_W-1:0]       dst_chan_q;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
    endfunction

    assign src_ready_out = ch_enable & ~full & {NUM_CH{arst_n}};
    assign push          = src_valid_in & src_ready_out;
    assign flush         = ~ch_enable;
    assign req           = ch_enable & ~empty;
    assign load_opp      = !dst_valid_q || dst_ready_in;
    assign beat_inc      = beat_cnt_q + BC_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        dsp_sync_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .arst_n  (arst_n),
            .push    (push[i]),
            .pop     (pop[i]),
            .flush   (flush[i]),
            .wr_data (src_data_in[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .count   (count[i]),
            .head    (head[i])
        );
    end

    // A pop drains the FIFO only if no push lands in the same cycle.
    always_comb begin
        req_ext = '0;
        req_ext[NUM_CH-1:0] = req;
        for (int i = 0; i < NUM_CH; i++) begin
            last_beat[i] = (count[i] == CNT_W'(1)) && !push[i];
        end
    end

    assign pick_ch = CH_W'(rr_pick(req_ext, CH_IDX_W'(rr_ptr_q)));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        pop_en     = 1'b0;
        pop_ch     = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (load_opp && (|req)) begin
                    pop_en     = 1'b1;
                    pop_ch     = pick_ch;
                    grant_d    = pick_ch;
                    beat_cnt_d = BC_W'(1);
                    if ((BURST_LEN == 1) || last_beat[pick_ch]) begin
                        rr_ptr_d = next_ch(pick_ch);
                    end else begin
                        state_d = ARB_BURST;
                    end
                end
            end
            ARB_BURST: begin
                if (!ch_enable[grant_q] || (load_opp && empty[grant_q])) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_ch(grant_q);
                end else if (load_opp) begin
                    pop_en     = 1'b1;
                    beat_cnt_d = beat_inc;
                    if ((beat_inc == BC_W'(BURST_LEN)) || last_beat[grant_q]) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_ch(grant_q);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = pop_en && (pop_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output register only reloads on a load opportunity, so it holds under backpressure.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_chan_q  <= '0;
        end else if (pop_en) begin
            dst_valid_q <= 1'b1;
            dst_data_q  <= head[pop_ch];
            dst_chan_q  <= pop_ch;
        end else if (dst_ready_in) begin
            dst_valid_q <= 1'b0;
        end
    end

    assign dst_valid_out = dst_valid_q;
    assign dst_data_out  = dst_data_q;
    assign dst_chan_out  = dst_chan_q;

`ifdef DSP_CHAN_MUX_STATS_EN
    logic [NUM_CH-1:0][STATS_W-1:0] beat_count_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            beat_count_q <= '0;
        end else if (stats_clr) begin
            beat_count_q <= '0;
        end else if (dst_valid_q && dst_ready_in) begin
            beat_count_q[dst_chan_q] <= beat_count_q[dst_chan_q] + STATS_W'(1);
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_dsp_chan_mux.sv
// Bench for dsp_chan_mux: directed scenarios plus randomized traffic against a queue-based model.
// Stats counters are exercised when DSP_CHAN_MUX_STATS_EN is defined.
module tb_dsp_chan_mux;
    import dsp_pkg::*;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int BL = 4;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              arst_n;
    logic [N-1:0]      ch_enable;
    logic [N-1:0][DW-1:0] src_data_in;
    logic [N-1:0]      src_valid_in;
    logic [N-1:0]      src_ready_out;
    logic [DW-1:0]     dst_data_out;
    logic [CW-1:0]     dst_chan_out;
    logic              dst_valid_out;
    logic              dst_ready_in;
`ifdef DSP_CHAN_MUX_STATS_EN
    logic                        stats_clr;
    logic [N-1:0][STATS_W-1:0]   beat_count;
`endif

    dsp_chan_mux #(
        .DATA_WIDTH (DW),
        .NUM_CH     (N),
        .FIFO_DEPTH (D),
        .BURST_LEN  (BL)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .ch_enable     (ch_enable),
        .src_data_in   (src_data_in),
        .src_valid_in  (src_valid_in),
        .src_ready_out (src_ready_out),
`ifdef DSP_CHAN_MUX_STATS_EN
        .stats_clr     (stats_clr),
        .beat_count    (beat_count),
`endif
        .dst_data_out  (dst_data_out),
        .dst_chan_out  (dst_chan_out),
        .dst_valid_out (dst_valid_out),
        .dst_ready_in  (dst_ready_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Source stimulus queues and log of delivered beats seen on the DUT egress
    logic [DW-1:0] sq[N][$];
    int            dl_ch[$];
    logic [DW-1:0] dl_dat[$];
    int            dl_t[$];

    // Reference model: FIFOs as queues, arbiter as plain integers
    logic [DW-1:0] mq[N][$];
    bit            m_burst;
    int            m_grant, m_rr, m_cnt;
    bit            m_ovld;
    logic [DW-1:0] m_odata;
    int            m_ochan;
    logic [31:0]   m_bc[N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            sq[i].delete();
            m_bc[i] = 0;
        end
        m_burst = 0; m_grant = 0; m_rr = 0; m_cnt = 0;
        m_ovld = 0; m_odata = '0; m_ochan = 0;
    endtask

    task automatic drive(input int pv);
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0 && $urandom_range(99) < pv) begin
                src_valid_in[i] = 1'b1;
                src_data_in[i]  = sq[i][0];
            end else begin
                src_valid_in[i] = 1'b0;
                src_data_in[i]  = DW'($urandom);
            end
        end
    endtask

    task automatic step();
        bit [N-1:0] mready, mpush;
        bit         load;
        int         popc, g;
        #1;
        for (int i = 0; i < N; i++) mready[i] = ch_enable[i] && (mq[i].size() < D);
        check("src_ready", src_ready_out, mready);
        check("dst_valid", dst_valid_out, m_ovld);
        if (m_ovld) begin
            check("dst_data", dst_data_out, m_odata);
            check("dst_chan", dst_chan_out, m_ochan);
        end
`ifdef DSP_CHAN_MUX_STATS_EN
        for (int i = 0; i < N; i++) check("beat_count", beat_count[i], m_bc[i]);
`endif
        if (dst_valid_out && dst_ready_in) begin
            dl_ch.push_back(int'(dst_chan_out));
            dl_dat.push_back(dst_data_out);
            dl_t.push_back(cyc);
        end
        for (int i = 0; i < N; i++) mpush[i] = src_valid_in[i] && mready[i];
        load = !m_ovld || dst_ready_in;
        popc = -1;
        if (!m_burst) begin
            if (load) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (popc < 0 && ch_enable[c] && mq[c].size() > 0) popc = c;
                end
            end
            if (popc >= 0) begin
                m_grant = popc;
                m_cnt   = 1;
                if (BL == 1 || (mq[popc].size() == 1 && !mpush[popc])) m_rr = (popc + 1) % N;
                else m_burst = 1;
            end
        end else begin
            g = m_grant;
            if (!ch_enable[g] || (load && mq[g].size() == 0)) begin
                m_burst = 0;
                m_rr    = (g + 1) % N;
            end else if (load) begin
                popc = g;
                m_cnt++;
                if (m_cnt == BL || (mq[g].size() == 1 && !mpush[g])) begin
                    m_burst = 0;
                    m_rr    = (g + 1) % N;
                end
            end
        end
`ifdef DSP_CHAN_MUX_STATS_EN
        if (stats_clr) begin
            for (int i = 0; i < N; i++) m_bc[i] = 0;
        end else if (m_ovld && dst_ready_in) begin
            m_bc[m_ochan] = m_bc[m_ochan] + 1;
        end
`endif
        if (popc >= 0) begin
            m_ovld  = 1;
            m_odata = mq[popc][0];
            m_ochan = popc;
            void'(mq[popc].pop_front());
        end else if (dst_ready_in) begin
            m_ovld = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (!ch_enable[i]) mq[i].delete();
            if (mpush[i]) mq[i].push_back(src_data_in[i]);
            if (src_valid_in[i] && src_ready_out[i]) void'(sq[i].pop_front());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int pv);
        repeat (n) begin
            drive(pv);
            step();
        end
    endtask

    task automatic clear_log();
        dl_ch.delete();
        dl_dat.delete();
        dl_t.delete();
    endtask

    task automatic do_reset();
        #2 arst_n = 1'b0;
        #1;
        check("rst_valid", dst_valid_out, 1'b0);
        check("rst_data", dst_data_out, '0);
        check("rst_chan", dst_chan_out, '0);
        check("rst_ready", src_ready_out, '0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        arst_n       = 1'b0;
        ch_enable    = '1;
        src_valid_in = '0;
        src_data_in  = '0;
        dst_ready_in = 1'b1;
`ifdef DSP_CHAN_MUX_STATS_EN
        stats_clr    = 1'b0;
`endif
        model_reset();
        #1;
        check("por_valid", dst_valid_out, 1'b0);
        check("por_ready", src_ready_out, '0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Single beat latency on ch2
        sq[2].push_back(16'h1234);
        run(1, 100);
        check("lat_t1_valid", dst_valid_out, 1'b0);
        run(1, 100);
        check("lat_t2_valid", dst_valid_out, 1'b1);
        check("lat_chan", dst_chan_out, 2'd2);
        check("lat_data", dst_data_out, 16'h1234);
        run(3, 100);

        // Preloaded channels, burst order with no idle cycles
        do_reset();
        dst_ready_in = 1'b0;
        for (int c = 0; c < N; c++)
            for (int b = 1; b <= 6; b++) sq[c].push_back(DW'((c << 8) | b));
        run(8, 100);
        dst_ready_in = 1'b1;
        clear_log();
        run(30, 100);
        check("order_len", dl_ch.size(), 24);
        if (dl_ch.size() == 24) begin
            int idx;
            idx = 0;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < N; c++)
                    for (int b = 0; b < (r == 0 ? 4 : 2); b++) begin
                        check("order_chan", dl_ch[idx], c);
                        check("order_data", dl_dat[idx], DW'((c << 8) | (r * 4 + b + 1)));
                        idx++;
                    end
            check("order_gapless", dl_t[23] - dl_t[0], 23);
        end

        // Backpressure while ch1 streams
        do_reset();
        dst_ready_in = 1'b0;
        for (int b = 0; b < 8; b++) sq[1].push_back(DW'(16'hA100 + b));
        run(10, 100);
        check("bp_accepted", 8 - sq[1].size(), D + 1);
        check("bp_hold_chan", dst_chan_out, 2'd1);
        check("bp_hold_data", dst_data_out, 16'hA100);
        dst_ready_in = 1'b1;
        clear_log();
        run(14, 100);
        check("bp_delivered", dl_ch.size(), 8);
        for (int b = 0; b < dl_dat.size(); b++) check("bp_seq", dl_dat[b], DW'(16'hA100 + b));

        // Disable ch0 mid-burst with 3 beats queued
        do_reset();
        dst_ready_in = 1'b0;
        for (int b = 0; b < 4; b++) sq[0].push_back(DW'(16'hB000 + b));
        for (int b = 0; b < 2; b++) sq[1].push_back(DW'(16'hC000 + b));
        run(6, 100);
        ch_enable[0] = 1'b0;
        dst_ready_in = 1'b1;
        clear_log();
        run(6, 100);
        check("dis_count", dl_ch.size(), 3);
        if (dl_ch.size() == 3) begin
            check("dis_first_chan", dl_ch[0], 0);
            check("dis_first_data", dl_dat[0], 16'hB000);
            check("dis_next_chan", dl_ch[1], 1);
            check("dis_last_chan", dl_ch[2], 1);
        end
        ch_enable[0] = 1'b1;

        // Reset mid-stream, first grant afterwards goes to ch0
        for (int c = 0; c < N; c++)
            for (int b = 0; b < 6; b++) sq[c].push_back(DW'($urandom));
        run(7, 100);
        do_reset();
        for (int c = N - 1; c >= 0; c--)
            for (int b = 0; b < 3; b++) sq[c].push_back(DW'((c << 12) | b));
        clear_log();
        run(10, 100);
        check("post_rst_grant", dl_ch.size() > 0 ? dl_ch[0] : -1, 0);

        // Randomized traffic
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < N; c++)
                if (sq[c].size() < 2) sq[c].push_back(DW'($urandom));
            if ($urandom_range(99) < 3) ch_enable[$urandom_range(N - 1)] ^= 1'b1;
            if ($urandom_range(99) < 5) ch_enable = '1;
            dst_ready_in = ($urandom_range(99) < 75);
`ifdef DSP_CHAN_MUX_STATS_EN
            stats_clr = ($urandom_range(99) < 2);
`endif
            run(1, 70);
        end
        ch_enable    = '1;
        dst_ready_in = 1'b1;
`ifdef DSP_CHAN_MUX_STATS_EN
        stats_clr = 1'b0;

        // Beat counters: five beats on ch3, then a clear in a handshake cycle
        do_reset();
        for (int b = 0; b < 5; b++) sq[3].push_back(DW'(16'hD000 + b));
        run(10, 100);
        check("stats_ch3", beat_count[3], 32'd5);
        sq[3].push_back(16'hD0FF);
        run(2, 100);
        stats_clr = 1'b1;
        run(1, 100);
        stats_clr = 1'b0;
        check("stats_clr", beat_count[3], 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
